// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory req/ack port of the memory stage
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - EX/MEM and MEM/WB registers with variable-latency data-memory access
module mem_stage_ctrl #(
    parameter int DATA_W   = 16,
    parameter int REG_BITS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic                byte_i,
    input  logic                unsigned_i,
    input  logic                reg_write_i,
    input  logic                wb_sel_i,
    input  logic [REG_BITS-1:0] rd_i,
    input  logic [DATA_W-1:0]   result_i,
    input  logic [DATA_W-1:0]   write_data_i,
    mem_stage_ctrl_if.master    mem,
    output logic                stall_o,
    output logic                err_o,
    output logic                wb_valid_o,
    output logic                reg_write_o,
    output logic                wb_sel_o,
    output logic [REG_BITS-1:0] rd_o,
    output logic [DATA_W-1:0]   result_o,
    output logic [DATA_W-1:0]   read_data_o
);
    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_n;

    logic                m_valid, m_read, m_write, m_byte, m_uns, m_regw, m_wbsel;
    logic [REG_BITS-1:0] m_rd;
    logic [DATA_W-1:0]   m_result, m_wdata;

    logic                done, held_kill;
    logic [DATA_W-1:0]   held_data;
    logic [15:0]         cnt;

    logic                mem_op, busy, ack_eff, hit, finish, advance, kill_now;
    logic [LANE_W-1:0]   lane;
    logic [7:0]          rbyte;
    logic [DATA_W-1:0]   ext_data, ld_now, wb_data;

    assign mem_op  = m_valid & (m_read | m_write);
    assign busy    = (state == BUSY);
    assign ack_eff = busy & mem.mem_ack;
    assign hit     = busy & ~mem.mem_ack & (cnt == 16'(TIMEOUT - 1));
    assign finish  = ack_eff | hit;
    assign advance = ~stall_o & ~stall_i;
    assign lane    = m_result[LANE_W-1:0];

    always_comb begin
        rbyte = mem.mem_rdata[{lane, 3'b000} +: 8];
        if (!m_byte)
            ext_data = mem.mem_rdata;
        else if (m_uns)
            ext_data = {{(DATA_W-8){1'b0}}, rbyte};
        else
            ext_data = {{(DATA_W-8){rbyte[7]}}, rbyte};
    end

    // A finished access that could not retire is replayed from the held copy
    assign ld_now   = (m_valid & m_read & ack_eff) ? ext_data : '0;
    assign wb_data  = done ? held_data : ld_now;
    assign kill_now = done ? held_kill : hit;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (mem_op && !done) state_n = BUSY;
            BUSY:    if (finish)          state_n = IDLE;
            default:                      state_n = IDLE;
        endcase
    end

    always_comb begin
        stall_o        = mem_op & ~done & ~finish;
        mem.mem_req    = busy;
        mem.mem_we     = busy & m_write;
        mem.mem_addr   = busy ? m_result : '0;
        mem.mem_wdata  = '0;
        mem.mem_be     = '0;
        if (busy) begin
            mem.mem_wdata = m_byte ? {NB{m_wdata[7:0]}} : m_wdata;
            mem.mem_be    = m_byte ? (NB'(1) << lane) : '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            err_o       <= 1'b0;
            done        <= 1'b0;
            held_kill   <= 1'b0;
            held_data   <= '0;
            m_valid     <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_byte      <= 1'b0;
            m_uns       <= 1'b0;
            m_regw      <= 1'b0;
            m_wbsel     <= 1'b0;
            m_rd        <= '0;
            m_result    <= '0;
            m_wdata     <= '0;
            wb_valid_o  <= 1'b0;
            reg_write_o <= 1'b0;
            wb_sel_o    <= 1'b0;
            rd_o        <= '0;
            result_o    <= '0;
            read_data_o <= '0;
        end else begin
            cnt <= (busy && !finish) ? cnt + 16'd1 : '0;
            if (hit)
                err_o <= 1'b1;
            if (advance) begin
                m_valid     <= valid_i & ~flush_i;
                m_read      <= mem_read_i;
                m_write     <= mem_write_i;
                m_byte      <= byte_i;
                m_uns       <= unsigned_i;
                m_regw      <= reg_write_i;
                m_wbsel     <= wb_sel_i;
                m_rd        <= rd_i;
                m_result    <= result_i;
                m_wdata     <= write_data_i;
                wb_valid_o  <= m_valid;
                reg_write_o <= m_valid & m_regw & ~kill_now;
                wb_sel_o    <= m_wbsel;
                rd_o        <= m_rd;
                result_o    <= m_result;
                read_data_o <= kill_now ? '0 : wb_data;
                done        <= 1'b0;
            end else if (finish) begin
                done      <= 1'b1;
                held_data <= ld_now;
                held_kill <= hit;
            end
        end
    end
endmodule
